ble_uart_rx_fifo: RTL and testbench
===================================

// Module: ble_uart_rx_fifo
// PURPOSE
// - Standalone UART receiver for the Boolean board BLE radio line (ble_uart_rx): the receive end of the BLE link.
// - Oversamples the async serial line, deframes bytes, buffers them in a first-word-fall-through FIFO.
// - Presents bytes on a valid/ready stream to fabric or an AXI-side reader; reports framing errors and overruns.
// PARAMETERS
// - CLK_HZ      100_000_000  system clock frequency (Hz)
// - BAUD        9600         line rate; bench overrides to 115200
// - OVERSAMPLE  16           samples per bit; even, >= 8
// - FIFO_DEPTH  16           byte entries; power of 2, >= 2
// PORTS
// - clk        in   1                    100 MHz system clock
// - resetn     in   1                    asynchronous active-low reset
// - rxd        in   1                    serial line from BLE module; idles high
// - rx_data    out  8                    FIFO head byte; valid when rx_valid=1
// - rx_valid   out  1                    FIFO not empty
// - rx_ready   in   1                    consumer accepts head when rx_valid & rx_ready
// - rx_count   out  $clog2(FIFO_DEPTH)+1 bytes held, 0..FIFO_DEPTH
// - frame_err  out  1                    1-cycle pulse: stop bit sampled low
// - overrun    out  1                    1-cycle pulse: byte dropped because FIFO full
// - parity_err out  1                    1-cycle pulse: parity mismatch (macro only; else tied 0)
// BEHAVIOUR
// - Reset (async assert, sync release): rx_data=0, rx_valid=0, rx_count=0, all pulses 0, FSM IDLE, FIFO empty, sync flops=1.
// - Reset mid-frame: partial byte discarded, FIFO contents lost; no pulses on exit.
// - rxd passes a 2-FF synchronizer before any use.
// - Tick divider: DIV = CLK_HZ/(BAUD*OVERSAMPLE), truncated; 1-cycle sample tick every DIV clocks; free-running, restarts on start edge.
// - FSM states: IDLE, START, DATA, [PARITY], STOP, BREAK.
//   IDLE:  synchronized rxd falling edge -> START, tick counter cleared.
//   START: after OVERSAMPLE/2 ticks sample; low -> DATA; high -> IDLE (glitch, no pulse).
//   DATA:  8 samples, one per OVERSAMPLE ticks, LSB first into shift reg -> STOP (or PARITY).
//   STOP:  sample one bit-time later; high -> push byte, IDLE; low -> frame_err pulse, byte dropped, BREAK.
//   BREAK: wait for synchronized rxd high -> IDLE (blocks restart during a held-low line).
// - Push occurs the clock after the stop sample; rx_valid rises the clock after push when FIFO was empty.
// - FIFO: FWFT, rd/wr pointers $clog2(FIFO_DEPTH)+1 bits, wrap modulo 2*DEPTH; full when MSBs differ and rest equal.
// - Pop when rx_valid & rx_ready; rx_data updates to next entry same edge.
// - Push when full and no pop same cycle: byte dropped, overrun pulse, count unchanged.
// - Push and pop same cycle: both performed (allowed when full), count unchanged, no overrun.
// - Pop when empty is ignored; rx_ready has no effect while rx_valid=0.
// - frame_err/overrun/parity_err never coincide for one byte; error byte never enters FIFO.
// CONFIGURATION
// - BLE_UART_RX_PARITY_EN defined: PARITY state after DATA samples a 9th bit; even parity over 8 data bits + parity bit;
//   mismatch -> parity_err pulse, byte dropped, still proceeds to STOP (stop low also gives frame_err instead).
// - Undefined: 8N1 framing, no PARITY state, parity_err tied 0.
// TESTING (BAUD=115200, DIV=54, bit = 864 clk)
// - Send 0xA5 8N1, rx_ready=0 -> rx_valid=1, rx_data=0xA5, rx_count=1; raise rx_ready 1 cycle -> count 0, rx_valid=0.
// - 200-clk low glitch on rxd -> no push, no pulses, FSM back to IDLE; following 0x5A received intact.
// - 0x3C with stop bit low, rxd held low 2 bit-times -> single frame_err pulse, count 0; next 0x55 received.
// - rx_ready=0, send 0x00..0x10 (17 bytes) -> count 16, one overrun pulse on 17th; drain yields 0x00..0x0F in order.
// - FIFO full, rx_ready=1 on exact push cycle of next byte 0x77 -> no overrun, count stays 16, 0x77 last out.
// - Assert resetn low mid-DATA of 0xC3 with 3 bytes queued -> count 0, rx_valid 0; next 0x81 received after release.
// - With BLE_UART_RX_PARITY_EN: 0x07 + parity bit 0 -> parity_err pulse, no push; 0x07 + parity 1 -> received.

Source files
------------

// File: rtl/ble_uart_rx_fifo.sv
// BLE UART receiver: 2-FF sync, oversampled 8N1 deframer, FWFT byte FIFO.
// Define BLE_UART_RX_PARITY_EN for 8E1 framing with parity_err reporting.
module ble_uart_rx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  logic          rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic          fall;
  logic [DW-1:0] div_q, div_d;
  logic          tick;
  logic [OW-1:0] os_q, os_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  state_e        state_q, state_d;
  logic          push_q, push_d;
  logic          fe_q, fe_d;
  logic          ovr_q, ovr_d;
  logic          pe_q, pe_d;
  logic          par_bad_q, par_bad_d;

  logic [AW:0]   wr_q, rd_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          empty, full, pop, wr_en;

  // s3 is only the previous synchronized value, used for edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
      rxd_s3_q <= 1'b1;
    end else begin
      rxd_s1_q <= rxd;
      rxd_s2_q <= rxd_s1_q;
      rxd_s3_q <= rxd_s2_q;
    end
  end

  assign fall = rxd_s3_q & ~rxd_s2_q;
  assign tick = (div_q == DW'(DIV - 1));

  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + 1'b1;
    os_d      = os_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    fe_d      = 1'b0;
    pe_d      = 1'b0;
    par_bad_d = par_bad_q;
    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          div_d   = '0;
          os_d    = '0;
        end
      end
      S_START: begin
        if (tick) begin
          os_d = os_q + 1'b1;
          if (os_q == OW'(OVERSAMPLE / 2 - 1)) begin
            os_d      = '0;
            bit_d     = '0;
            par_bad_d = 1'b0;
            state_d   = rxd_s2_q ? S_IDLE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          os_d = os_q + 1'b1;
          if (os_q == OW'(OVERSAMPLE - 1)) begin
            os_d    = '0;
            shift_d = {rxd_s2_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef BLE_UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
      end
`ifdef BLE_UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          os_d = os_q + 1'b1;
          if (os_q == OW'(OVERSAMPLE - 1)) begin
            os_d      = '0;
            par_bad_d = ^{shift_q, rxd_s2_q};
            state_d   = S_STOP;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          os_d = os_q + 1'b1;
          if (os_q == OW'(OVERSAMPLE - 1)) begin
            os_d = '0;
            if (rxd_s2_q) begin
              state_d = S_IDLE;
              pe_d    = par_bad_q;
              push_d  = ~par_bad_q;
            end else begin
              state_d = S_BREAK;
              fe_d    = 1'b1;
            end
          end
        end
      end
      S_BREAK: begin
        if (rxd_s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      os_q      <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      os_q      <= os_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      par_bad_q <= par_bad_d;
    end
  end

  // FIFO: extra pointer MSB separates full from empty
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = ~empty & rx_ready;
  assign wr_en = push_q & (~full | pop);
  assign ovr_d = push_q & full & ~pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= shift_q;
  end

  assign rx_valid  = ~empty;
  assign rx_data   = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
  assign rx_count  = wr_q - rd_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;
`ifdef BLE_UART_RX_PARITY_EN
  assign parity_err = pe_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ble_uart_rx_fifo.sv
// Directed bench for ble_uart_rx_fifo: vector table plus multi-cycle sequences.
// Clock scaled so one bit is 128 clocks at 115200 baud (DIV=8).
module tb_ble_uart_rx_fifo;

  localparam int CLK_HZ = 14_745_600;
  localparam int BAUD   = 115200;
  localparam int OS     = 16;
  localparam int DEPTH  = 16;
  localparam int DIV    = CLK_HZ / (BAUD * OS);
  localparam int BIT    = DIV * OS;
  // start-edge detect latency plus half a bit: stop sample offset in stop bit
  localparam int SAMP   = 3 + (OS / 2) * DIV;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [4:0] rx_count;
  logic       frame_err, overrun, parity_err;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_n = 0, ov_n = 0, pe_n = 0;
  logic par_flip = 1'b0;

  ble_uart_rx_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD),
    .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .resetn(resetn), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_count(rx_count),
    .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err)  fe_n++;
    if (overrun)    ov_n++;
    if (parity_err) pe_n++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pop;
    int         cnt;
    int         fe;
  } vec_t;

  vec_t tbl[6];

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic pop_at_push);
    rxd = 1'b0;
    wait_clk(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_clk(BIT);
    end
`ifdef BLE_UART_RX_PARITY_EN
    rxd = (^d) ^ par_flip;
    wait_clk(BIT);
`endif
    rxd = stop;
    if (pop_at_push) begin
      wait_clk(SAMP);
      rx_ready = 1'b1;
      wait_clk(1);
      rx_ready = 1'b0;
      wait_clk(BIT - SAMP - 1);
    end else begin
      wait_clk(BIT);
    end
    if (stop) rxd = 1'b1;
  endtask

  task automatic pop1;
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    int fe0, ov0, pe0;
    logic [7:0] exp_q [$];

    tbl[0] = '{8'hA5, 1'b1, 1'b1, 1, 0};
    tbl[1] = '{8'h3C, 1'b0, 1'b0, 0, 1};
    tbl[2] = '{8'h55, 1'b1, 1'b1, 1, 0};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 1, 0};
    tbl[4] = '{8'h01, 1'b1, 1'b1, 1, 0};
    tbl[5] = '{8'h80, 1'b1, 1'b1, 1, 0};

    wait_clk(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_count", rx_count, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_pulses", {frame_err, overrun, parity_err}, 0);
    resetn = 1'b1;
    wait_clk(BIT);

    for (int v = 0; v < 6; v++) begin
      fe0 = fe_n;
      send_frame(tbl[v].data, tbl[v].stop, 1'b0);
      if (!tbl[v].stop) begin
        wait_clk(BIT);
        rxd = 1'b1;
        wait_clk(BIT);
      end
      chk($sformatf("v%0d_count", v), rx_count, tbl[v].cnt);
      chk($sformatf("v%0d_valid", v), rx_valid, tbl[v].cnt != 0);
      chk($sformatf("v%0d_fe", v), fe_n - fe0, tbl[v].fe);
      if (tbl[v].cnt != 0)
        chk($sformatf("v%0d_data", v), rx_data, tbl[v].data);
      if (tbl[v].pop) begin
        pop1();
        chk($sformatf("v%0d_pop_count", v), rx_count, 0);
        chk($sformatf("v%0d_pop_valid", v), rx_valid, 0);
      end
    end

    fe0 = fe_n; ov0 = ov_n; pe0 = pe_n;
    rxd = 1'b0;
    wait_clk(30);
    rxd = 1'b1;
    wait_clk(2 * BIT);
    chk("glitch_count", rx_count, 0);
    chk("glitch_pulses", (fe_n - fe0) + (ov_n - ov0) + (pe_n - pe0), 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("after_glitch_count", rx_count, 1);
    chk("after_glitch_data", rx_data, 8'h5A);
    pop1();

    ov0 = ov_n;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1'b0);
    chk("fill_count", rx_count, 16);
    chk("fill_no_ovr", ov_n - ov0, 0);
    send_frame(8'h10, 1'b1, 1'b0);
    chk("ovr_count", rx_count, 16);
    chk("ovr_pulse", ov_n - ov0, 1);
    chk("ovr_head", rx_data, 8'h00);

    ov0 = ov_n;
    send_frame(8'h77, 1'b1, 1'b1);
    chk("pushpop_count", rx_count, 16);
    chk("pushpop_no_ovr", ov_n - ov0, 0);
    for (int i = 1; i < 16; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h77);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), rx_data, exp_q[i]);
      pop1();
    end
    chk("drain_count", rx_count, 0);
    chk("drain_valid", rx_valid, 0);

    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b0);
    chk("q3_count", rx_count, 3);
    rxd = 1'b0;
    wait_clk(BIT);
    rxd = 1'b1;
    wait_clk(2 * BIT + BIT / 2);
    resetn = 1'b0;
    wait_clk(2);
    chk("midrst_count", rx_count, 0);
    chk("midrst_valid", rx_valid, 0);
    wait_clk(2);
    resetn = 1'b1;
    fe0 = fe_n; ov0 = ov_n; pe0 = pe_n;
    wait_clk(2 * BIT);
    chk("postrst_pulses", (fe_n - fe0) + (ov_n - ov0) + (pe_n - pe0), 0);
    chk("postrst_count", rx_count, 0);
    send_frame(8'h81, 1'b1, 1'b0);
    chk("postrst_rx_count", rx_count, 1);
    chk("postrst_rx_data", rx_data, 8'h81);
    pop1();

`ifdef BLE_UART_RX_PARITY_EN
    pe0 = pe_n;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    par_flip = 1'b0;
    chk("par_bad_pulse", pe_n - pe0, 1);
    chk("par_bad_count", rx_count, 0);
    send_frame(8'h07, 1'b1, 1'b0);
    chk("par_ok_count", rx_count, 1);
    chk("par_ok_data", rx_data, 8'h07);
    chk("par_ok_no_pulse", pe_n - pe0, 1);
    pop1();
`else
    chk("no_parity_err", pe_n, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
